coef_bank: RTL and testbench

COEF_BANK -- requirements
Module: coef_bank

---
 rtl/coef_bank.sv | 149 ++++++++++++++
 tb/tb_coef_bank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_bank.sv
// coef_bank: banked coefficient register file with a latency-1 random-read port,
// a guarded write port and a valid/ready sequencer that streams one full set.
module coef_bank #(
    parameter int COEF_W = 9,
    parameter int ADDR_W = 3,
    parameter int NSETS  = 2,
    localparam int DEPTH = 2**ADDR_W,
    localparam int SEL_W = (NSETS > 1) ? $clog2(NSETS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  rd_set,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COEF_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_set,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic [SEL_W-1:0]  seq_set,
    output logic [COEF_W-1:0] seq_data,
    output logic [ADDR_W-1:0] seq_idx,
    output logic              seq_valid,
    input  logic              seq_ready,
    output logic              seq_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_set;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_seq_valid;
    logic                r_busy;
    logic                r_done;
    logic [COEF_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_wr_err;
    logic [COEF_W-1:0]   r_mem [NSETS][DEPTH];
    logic                w_wr_ok;

    function automatic logic setOk(input logic [SEL_W-1:0] s);
        return (32'(s) < 32'(NSETS));
    endfunction

    // Power-on contents: set 0 holds a 9-bit default table, sign-extended to COEF_W.
    function automatic logic [COEF_W-1:0] defCoef(input int s, input int a);
        logic [8:0] v;
        v = 9'h000;
        if (s == 0) begin
            case (a)
                0:       v = 9'h04C;
                1:       v = 9'h096;
                2:       v = 9'h1D5;
                3:       v = 9'h1AC;
                4:       v = 9'h080;
                5:       v = 9'h195;
                6:       v = 9'h1EC;
                7:       v = 9'h01D;
                default: v = 9'h000;
            endcase
        end
        return {{(COEF_W-8){v[8]}}, v[7:0]};
    endfunction

    // The set being streamed is locked against writes so a stream is a coherent snapshot.
    assign w_wr_ok = wr_en && setOk(wr_set) && !(r_busy && (wr_set == r_set));

    for (genvar s = 0; s < NSETS; s++) begin : g_set
        for (genvar a = 0; a < DEPTH; a++) begin : g_addr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[s][a] <= defCoef(s, a);
                end else if (w_wr_ok && (wr_set == SEL_W'(s)) && (wr_addr == ADDR_W'(a))) begin
                    r_mem[s][a] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= setOk(rd_set) ? r_mem[rd_set][rd_addr] : '0;
            end
            r_wr_err <= wr_en && !w_wr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_set       <= '0;
            r_idx       <= '0;
            r_seq_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && setOk(seq_set)) begin
                        r_state     <= S_STREAM;
                        r_set       <= seq_set;
                        r_idx       <= '0;
                        r_seq_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (seq_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= S_IDLE;
                            r_idx       <= '0;
                            r_seq_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign wr_err    = r_wr_err;
    assign seq_data  = r_mem[r_set][r_idx];
    assign seq_idx   = r_idx;
    assign seq_valid = r_seq_valid;
    assign seq_last  = r_seq_valid && (r_idx == LAST_IDX);
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_coef_bank.sv
// tb_coef_bank: directed stimulus with a queue scoreboard; a negedge monitor
// checks reads, write errors, stream beats and done pulses against the queues.
module tb_coef_bank;

    localparam int COEF_W = 9;
    localparam int ADDR_W = 3;
    localparam int NSETS  = 3;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [COEF_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              rd_en;
    logic [SEL_W-1:0]  rd_set;
    logic [ADDR_W-1:0] rd_addr;
    logic [COEF_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [SEL_W-1:0]  wr_set;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              wr_err;
    logic              start;
    logic [SEL_W-1:0]  seq_set;
    logic [COEF_W-1:0] seq_data;
    logic [ADDR_W-1:0] seq_idx;
    logic              seq_valid;
    logic              seq_ready;
    logic              seq_last;
    logic              busy;
    logic              done;

    int nChecks = 0;
    int nErrors = 0;

    logic [COEF_W-1:0] expMem [NSETS][8];
    logic [COEF_W-1:0] rdQ [$];
    logic              wrQ [$];
    beat_t             seqQ [$];

    logic  rdSeen, wrSeen, expDone, stalled;
    beat_t held;

    coef_bank #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .NSETS(NSETS)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_set(rd_set), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_set(wr_set), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err),
        .start(start), .seq_set(seq_set),
        .seq_data(seq_data), .seq_idx(seq_idx), .seq_valid(seq_valid),
        .seq_ready(seq_ready), .seq_last(seq_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        logic [COEF_W-1:0] defs [8];
        defs = '{9'h04C, 9'h096, 9'h1D5, 9'h1AC, 9'h080, 9'h195, 9'h1EC, 9'h01D};
        for (int s = 0; s < NSETS; s++)
            for (int a = 0; a < 8; a++)
                expMem[s][a] = (s == 0) ? defs[a] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushStream(input int s);
        beat_t b;
        for (int a = 0; a < 8; a++) begin
            b.idx  = 3'(a);
            b.data = expMem[s][a];
            b.last = (a == 7);
            seqQ.push_back(b);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_data"}, rd_data, 0);
        checkOutput({tag, "_rd_valid"}, rd_valid, 0);
        checkOutput({tag, "_wr_err"}, wr_err, 0);
        checkOutput({tag, "_seq_valid"}, seq_valid, 0);
        checkOutput({tag, "_seq_last"}, seq_last, 0);
        checkOutput({tag, "_seq_idx"}, seq_idx, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdSeen <= 1'b0;
            wrSeen <= 1'b0;
        end else begin
            rdSeen <= rd_en;
            wrSeen <= wr_en;
        end
    end

    // Monitor: consumes expected responses as the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            expDone = 1'b0;
            stalled = 1'b0;
        end else begin
            checkOutput("done_pulse", done, expDone);
            expDone = 1'b0;
            if (rdSeen) begin
                checkOutput("rd_valid", rd_valid, 1);
                if (rdQ.size() > 0) checkOutput("rd_data", rd_data, rdQ.pop_front());
                else begin
                    nChecks++; nErrors++;
                    $display("[TB] FAIL rd_queue: read response with no expected value, got 0x%0h", rd_data);
                end
            end else begin
                checkOutput("rd_valid_idle", rd_valid, 0);
            end
            if (wrSeen) begin
                if (wrQ.size() > 0) checkOutput("wr_err", wr_err, wrQ.pop_front());
                else begin
                    nChecks++; nErrors++;
                    $display("[TB] FAIL wr_queue: write response with no expected value, got %0b", wr_err);
                end
            end else begin
                checkOutput("wr_err_idle", wr_err, 0);
            end
            if (seq_valid) begin
                if (stalled) begin
                    checkOutput("stall_data", seq_data, held.data);
                    checkOutput("stall_idx", seq_idx, held.idx);
                    checkOutput("stall_last", seq_last, held.last);
                end
                if (seq_ready) begin
                    stalled = 1'b0;
                    if (seqQ.size() > 0) begin
                        beat_t b;
                        b = seqQ.pop_front();
                        checkOutput("beat_idx", seq_idx, b.idx);
                        checkOutput("beat_data", seq_data, b.data);
                        checkOutput("beat_last", seq_last, b.last);
                        expDone = b.last;
                    end else begin
                        nChecks++; nErrors++;
                        $display("[TB] FAIL seq_queue: unexpected beat idx %0d data 0x%0h", seq_idx, seq_data);
                    end
                end else begin
                    stalled = 1'b1;
                    held.idx = seq_idx;
                    held.data = seq_data;
                    held.last = seq_last;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic applyStimulus();
        int n;
        logic got;

        rst_n = 0; rd_en = 0; rd_set = 0; rd_addr = 0;
        wr_en = 0; wr_set = 0; wr_addr = 0; wr_data = 0;
        start = 0; seq_set = 0; seq_ready = 0;
        resetModel();
        #2;
        checkAllZero("reset");
        tick();
        rst_n = 1;
        tick();

        $display("[TB] back-to-back reads of set 0 defaults");
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_set = 0; rd_addr = 3'(i);
            rdQ.push_back(expMem[0][i]);
            tick();
        end
        rd_en = 0;
        tick();
        checkOutput("rd_hold_data", rd_data, 9'h01D);
        checkOutput("rd_hold_valid", rd_valid, 0);

        $display("[TB] read-before-write and invalid set");
        wr_en = 1; wr_set = 1; wr_addr = 2; wr_data = 9'h1FF; wrQ.push_back(0);
        rd_en = 1; rd_set = 1; rd_addr = 2; rdQ.push_back(9'h000);
        tick();
        expMem[1][2] = 9'h1FF;
        wr_en = 0;
        rdQ.push_back(9'h1FF);
        tick();
        rd_set = 3; rd_addr = 1; rdQ.push_back(9'h000);
        wr_en = 1; wr_set = 3; wr_addr = 0; wr_data = 9'h0AA; wrQ.push_back(1);
        tick();
        rd_en = 0; wr_en = 0;
        tick();

        $display("[TB] stream set 0 with stalls and concurrent traffic");
        seq_ready = 0; start = 1; seq_set = 0;
        pushStream(0);
        tick();
        checkOutput("stream_busy", busy, 1);
        checkOutput("stream_valid", seq_valid, 1);
        seq_set = 1;
        wr_en = 1; wr_set = 0; wr_addr = 3; wr_data = 9'h055; wrQ.push_back(1);
        rd_en = 1; rd_set = 0; rd_addr = 1; rdQ.push_back(expMem[0][1]);
        tick();
        start = 0; rd_en = 0; seq_ready = 1;
        wr_set = 1; wr_addr = 5; wr_data = 9'h123; wrQ.push_back(0);
        tick();
        expMem[1][5] = 9'h123;
        wr_en = 0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            seq_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (done) begin
                got = 1;
                break;
            end
        end
        checkOutput("stream1_done_seen", got, 1);
        checkOutput("after_done_busy", busy, 0);
        checkOutput("after_done_valid", seq_valid, 0);

        $display("[TB] start on done cycle, set 1, ready held high");
        start = 1; seq_set = 1; seq_ready = 1;
        pushStream(1);
        n = 0; got = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n++;
            start = 0;
            if (done) begin
                got = 1;
                break;
            end
        end
        checkOutput("stream2_done_seen", got, 1);
        checkOutput("stream2_cycles", n, 9);

        $display("[TB] invalid start set");
        start = 1; seq_set = 3;
        tick();
        start = 0;
        checkOutput("bad_start_busy", busy, 0);
        checkOutput("bad_start_valid", seq_valid, 0);
        tick();
        checkOutput("bad_start_valid2", seq_valid, 0);

        wr_en = 1; wr_set = 0; wr_addr = 0; wr_data = 9'h111; wrQ.push_back(0);
        tick();
        expMem[0][0] = 9'h111;
        wr_en = 0;
        rd_en = 1; rd_set = 0; rd_addr = 0; rdQ.push_back(expMem[0][0]);
        tick();
        rd_en = 0;
        tick();

        $display("[TB] reset in the middle of a stream");
        start = 1; seq_set = 0; seq_ready = 1;
        pushStream(0);
        tick();
        start = 0;
        repeat (4) tick();
        checkOutput("mid_idx", seq_idx, 4);
        #1;
        rst_n = 0;
        seqQ.delete();
        resetModel();
        #1;
        checkAllZero("midreset");
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no_resume_valid", seq_valid, 0);
            checkOutput("no_resume_busy", busy, 0);
        end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_set = 0; rd_addr = 3'(i);
            rdQ.push_back(expMem[0][i]);
            tick();
        end
        rd_set = 1; rd_addr = 2; rdQ.push_back(expMem[1][2]);
        tick();
        rd_addr = 5; rdQ.push_back(expMem[1][5]);
        tick();
        rd_en = 0;
        repeat (3) tick();

        checkOutput("rd_queue_drained", rdQ.size(), 0);
        checkOutput("wr_queue_drained", wrQ.size(), 0);
        checkOutput("seq_queue_drained", seqQ.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
